host_specific_top_tx_to_host: RTL and testbench

HOST_SPECIFIC_TOP_TX_TO_HOST -- requirements
Module: host_specific_top_tx_to_host

---
 rtl/host_specific_top_tx_to_host.sv | 154 +++++++++++++++
 tb/tb_host_specific_top_tx_to_host.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/host_specific_top_tx_to_host.sv
// Link-to-host receive path: Manchester-decodes 144-bit beats and assembles
// a multi-beat response packet, pulsing done or error once per packet.
module host_specific_top_tx_to_host #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_PAYLOAD    = 116
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [143:0]  encoded_input,
    input  logic          encoded_valid,
    output logic          encoded_ready,
    output logic [1023:0] output_data,
    output logic          done,
    output logic          error
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE, ERROR} state_t;

    state_t          state_q, state_d;
    logic [1023:0]   data_q, data_d;
    logic [7:0]      size_q, size_d;
    logic [7:0]      beats_q, beats_d;
    logic [7:0]      idx_q, idx_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic [71:0]     dec;
    logic            sym_err;
    logic            xfer;
    logic [7:0]      opcode;
    logic [7:0]      n_size;
    logic            hdr_err;

    function automatic logic [7:0] beats_of(input logic [7:0] n);
        if (n <= 8'd1) return 8'd1;
        return 8'(1 + (int'(n) + 7) / 9);
    endfunction

    // Bytes at or beyond 8+N belong to no field and are forced to zero.
    function automatic logic [1023:0] keep_bytes(input logic [1023:0] d,
                                                 input logic [7:0] n);
        logic [1023:0] r;
        r = d;
        for (int j = 0; j < 128; j++) begin
            if (j >= 8 + int'(n)) r[8*j +: 8] = 8'h00;
        end
        return r;
    endfunction

    always_comb begin
        sym_err = 1'b0;
        dec     = '0;
        for (int i = 0; i < 72; i++) begin
            dec[i] = encoded_input[2*i+1];
            if (encoded_input[2*i+1] == encoded_input[2*i]) sym_err = 1'b1;
        end
    end

    assign opcode        = dec[7:0];
    assign n_size        = dec[63:56];
    assign hdr_err       = !(opcode == 8'h02 || opcode == 8'h04) ||
                           (int'(n_size) > MAX_PAYLOAD);
    assign encoded_ready = !reset && (state_q == IDLE || state_q == COLLECT);
    assign xfer          = encoded_valid && encoded_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        size_d  = size_q;
        beats_d = beats_q;
        idx_d   = idx_q;
        idle_d  = idle_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    data_d        = '0;
                    data_d[71:0]  = dec;
                    data_d        = keep_bytes(data_d, n_size);
                    size_d        = n_size;
                    beats_d       = beats_of(n_size);
                    idx_d         = 8'd1;
                    idle_d        = '0;
                    if (sym_err || hdr_err) begin
                        data_d  = '0;
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else if (beats_of(n_size) == 8'd1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (xfer) begin
                    data_d[72*int'(idx_q) +: 72] = dec;
                    data_d = keep_bytes(data_d, size_q);
                    idx_d  = idx_q + 8'd1;
                    idle_d = '0;
                    if (sym_err) begin
                        data_d  = '0;
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else if (idx_q + 8'd1 == beats_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else if (int'(idle_q) + 1 >= TIMEOUT_CYCLES) begin
                    data_d  = '0;
                    state_d = ERROR;
                    error_d = 1'b1;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            size_q  <= '0;
            beats_q <= '0;
            idx_q   <= '0;
            idle_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            size_q  <= size_d;
            beats_q <= beats_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign output_data = data_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_host_specific_top_tx_to_host.sv
// Scoreboard bench: stimulus pushes expected packets, a forked monitor
// pops and compares on every done/error pulse.
module tb_host_specific_top_tx_to_host;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [143:0]  encoded_input = '0;
    logic          encoded_valid = 1'b0;
    logic          encoded_ready;
    logic [1023:0] output_data;
    logic          done;
    logic          error;

    host_specific_top_tx_to_host dut (
        .clk           (clk),
        .reset         (reset),
        .encoded_input (encoded_input),
        .encoded_valid (encoded_valid),
        .encoded_ready (encoded_ready),
        .output_data   (output_data),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_err;
        logic [1023:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [143:0] encode(input logic [71:0] d);
        logic [143:0] e;
        for (int i = 0; i < 72; i++) e[2*i +: 2] = d[i] ? 2'b10 : 2'b01;
        return e;
    endfunction

    task automatic check1(input string name, input logic act, input logic req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, req);
        end
    endtask

    task automatic check_data(input string name, input logic [1023:0] act,
                              input logic [1023:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            for (int w = 0; w < 16; w++) begin
                if (act[64*w +: 64] !== req[64*w +: 64]) begin
                    $display("FAIL %s: word %0d got %h expected %h", name, w,
                             act[64*w +: 64], req[64*w +: 64]);
                    break;
                end
            end
        end
    endtask

    task automatic push(input logic is_err, input logic [1023:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [143:0] enc);
        int n;
        @(negedge clk);
        encoded_valid = 1'b1;
        encoded_input = enc;
        n = 0;
        while (!encoded_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL send: ready stuck at 0 expected 1");
        end
        @(posedge clk);
        #1 encoded_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d packets outstanding expected 0", name,
                     exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    logic [71:0]   ack, yaw0, yaw1, b72;
    logic [1023:0] exp_d;
    logic [143:0]  enc;
    logic [7:0]    bytes [126];

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (done && error) check1("done_and_error", 1'b1, 1'b0);
                if (done || error) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_pulse: done=%0b error=%0b expected none",
                                 done, error);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check1("pulse_is_error", error, e.is_err);
                        check_data("pulse_data", output_data, e.data);
                    end
                end
            end
        join_none

        ack  = 72'h0101FFFFFFFFFFFF02;
        yaw0 = 72'h100AA6A5A4A3A2A104;
        yaw1 = 72'h191817161514131211;

        repeat (3) @(negedge clk);
        check1("ready_in_reset", encoded_ready, 1'b0);
        check1("done_in_reset", done, 1'b0);
        check1("error_in_reset", error, 1'b0);
        check_data("data_in_reset", output_data, '0);
        reset = 1'b0;
        @(negedge clk);
        check1("ready_after_reset", encoded_ready, 1'b1);

        push(1'b0, {952'd0, ack});
        send(encode(ack));
        drain("ack");
        repeat (3) @(negedge clk);
        check_data("idle_hold", output_data, {952'd0, ack});

        push(1'b0, {880'd0, yaw1, yaw0});
        send(encode(yaw0));
        send(encode(yaw1));
        drain("yaw2");

        push(1'b0, {952'd0, 72'h0066554433221102});
        send(encode(72'hEE0066554433221102));
        drain("n0_mask");

        enc = encode(ack);
        enc[1:0] = 2'b11;
        push(1'b1, '0);
        send(enc);
        @(negedge clk);
        check1("ready_in_error", encoded_ready, 1'b0);
        @(negedge clk);
        check1("ready_after_error", encoded_ready, 1'b1);
        drain("bad_symbol");

        push(1'b1, '0);
        send(encode(72'h0101FFFFFFFFFFFF05));
        drain("bad_opcode");
        push(1'b1, '0);
        send(encode(72'h0175FFFFFFFFFFFF02));
        drain("bad_size");

        for (int j = 0; j < 126; j++) bytes[j] = 8'(j);
        bytes[0] = 8'h04;
        bytes[7] = 8'h74;
        exp_d = '0;
        for (int j = 0; j < 124; j++) exp_d[8*j +: 8] = bytes[j];
        push(1'b0, exp_d);
        for (int k = 0; k < 14; k++) begin
            for (int m = 0; m < 9; m++) b72[8*m +: 8] = bytes[9*k + m];
            send(encode(b72));
        end
        drain("max_payload");

        push(1'b1, '0);
        send(encode(yaw0));
        drain("timeout");

        push(1'b0, {880'd0, yaw1, yaw0});
        send(encode(yaw0));
        repeat (63) @(posedge clk);
        send(encode(yaw1));
        drain("late_beat");

        send(encode(yaw0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check1("ready_mid_reset", encoded_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        check_data("data_after_reset", output_data, '0);
        @(negedge clk);
        check1("ready_after_reset2", encoded_ready, 1'b1);
        push(1'b0, {952'd0, ack});
        send(encode(ack));
        drain("after_reset_ack");

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
